// File: rtl/apb_cmd_master.sv
// APB master transactor: queues register commands, runs SETUP/ACCESS to one of NUM_SEL
// slaves and returns one in-order response per command, with decode-error and timeout.
module apb_cmd_master #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SEL     = 1,
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 256,
  localparam int SEL_W      = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [SEL_W-1:0]      cmd_sel,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [NUM_SEL-1:0]    psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic                  busy
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] CNT_MAX = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  typedef struct packed {
    logic                  write;
    logic [SEL_W-1:0]      sel;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  state_t            state, state_nxt;
  cmd_t              mem [CMD_DEPTH];
  cmd_t              in_cmd, nxt;
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [SEL_W-1:0]  cur_sel;
  logic [TW-1:0]     wait_cnt;
  logic              empty, full, push, bypass, load, pop, fifo_wr, dec_err, timed_out, done;

  assign in_cmd    = '{write: cmd_write, sel: cmd_sel, addr: cmd_addr, wdata: cmd_wdata};
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push      = cmd_valid && !full;
  // An idle master with an empty queue takes the command straight from the port,
  // which keeps push-to-SETUP at one cycle.
  assign bypass    = (state == IDLE) && empty && push;
  assign load      = ((state == IDLE) && (!empty || push)) ||
                     ((state == RESP) && rsp_ready && !empty);
  assign pop       = load && !bypass;
  assign fifo_wr   = push && !bypass;
  assign nxt       = bypass ? in_cmd : mem[rd_ptr[AW-1:0]];
  assign dec_err   = int'(nxt.sel) >= NUM_SEL;
  assign timed_out = (TIMEOUT_CYC != 0) && (wait_cnt == CNT_MAX) && !pready;
  assign done      = (state == ACCESS) && (pready || timed_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = dec_err ? RESP : SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = load ? (dec_err ? RESP : SETUP) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = !full;
    rsp_valid = (state == RESP);
    penable   = (state == ACCESS);
    busy      = !empty || (state != IDLE);
    psel      = '0;
    for (int i = 0; i < NUM_SEL; i++)
      psel[i] = ((state == SETUP) || (state == ACCESS)) && (cur_sel == SEL_W'(i));
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr[AW-1:0]] <= in_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cur_sel     <= '0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      wait_cnt    <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
      // Bus fields only change for a real transfer so paddr/pwdata hold across decode errors.
      if (load && !dec_err) begin
        cur_sel <= nxt.sel;
        paddr   <= nxt.addr;
        pwrite  <= nxt.write;
        pwdata  <= nxt.wdata;
      end
      if (load && dec_err) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b0;
      end
      if (state == SETUP)                wait_cnt <= '0;
      else if (state == ACCESS && !pready) wait_cnt <= wait_cnt + TW'(1);
      if (done) begin
        rsp_rdata   <= (pready && !pwrite && !pslverr) ? prdata : '0;
        rsp_err     <= pready ? pslverr : 1'b1;
        rsp_timeout <= !pready;
      end
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: three slaves, 4-deep queue, 8-cycle timeout.
module tb_apb_cmd_master;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [1:0]  cmd_sel;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [2:0]  psel;
  logic        penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr, busy;

  int total = 0;
  int bad   = 0;

  apb_cmd_master #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_SEL(3), .CMD_DEPTH(4), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_sel(cmd_sel),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are checked there before driving.
  task automatic drive_cmd(input logic w, input logic [1:0] s, input logic [15:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_sel = s; cmd_addr = a; cmd_wdata = d;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_sel = 0; cmd_addr = 0; cmd_wdata = 0;
    rsp_ready = 0; prdata = 0; pready = 0; pslverr = 0;
    repeat (2) @(negedge clk);
    total++; if ({cmd_ready, rsp_valid, psel, penable, busy} !== 7'b1000000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=1000000", {cmd_ready, rsp_valid, psel, penable, busy}); end
    total++; if ({paddr, pwrite, pwdata, rsp_rdata, rsp_err, rsp_timeout} !== '0) begin
      bad++; $display("FAIL reset_data paddr=%h pwdata=%h rdata=%h want 0", paddr, pwdata, rsp_rdata); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write;
    pready = 1;
    drive_cmd(1'b1, 2'd0, 16'h0010, 32'hDEADBEEF);
    @(negedge clk); cmd_valid = 0;
    total++; if ({psel, penable, pwrite, rsp_valid, paddr, pwdata} !== {3'b001, 1'b0, 1'b1, 1'b0, 16'h0010, 32'hDEADBEEF}) begin
      bad++; $display("FAIL wr_setup psel=%b en=%b wr=%b addr=%h data=%h", psel, penable, pwrite, paddr, pwdata); end
    @(negedge clk);
    total++; if ({psel, penable, rsp_valid} !== 5'b00110) begin
      bad++; $display("FAIL wr_access got=%b want=00110", {psel, penable, rsp_valid}); end
    @(negedge clk);
    total++; if ({rsp_valid, rsp_err, rsp_timeout, psel, penable, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0}) begin
      bad++; $display("FAIL wr_resp v=%b err=%b to=%b psel=%b rdata=%h", rsp_valid, rsp_err, rsp_timeout, psel, rsp_rdata); end
    rsp_ready = 1;
    @(negedge clk); rsp_ready = 0;
    total++; if ({rsp_valid, busy} !== 2'b00) begin
      bad++; $display("FAIL wr_done got=%b want=00", {rsp_valid, busy}); end
  endtask

  task automatic test_read_wait;
    pready = 0;
    drive_cmd(1'b0, 2'd0, 16'h0020, 32'h0);
    @(negedge clk); cmd_valid = 0;
    total++; if ({psel, penable, pwrite, paddr} !== {3'b001, 1'b0, 1'b0, 16'h0020}) begin
      bad++; $display("FAIL rd_setup psel=%b en=%b wr=%b addr=%h", psel, penable, pwrite, paddr); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if ({psel, penable, rsp_valid} !== 5'b00110) begin
        bad++; $display("FAIL rd_wait%0d got=%b want=00110", i, {psel, penable, rsp_valid}); end
    end
    pready = 1; prdata = 32'h12345678;
    @(negedge clk); pready = 0; prdata = 0;
    total++; if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, 32'h12345678}) begin
      bad++; $display("FAIL rd_resp v=%b err=%b to=%b rdata=%h want 1 0 0 12345678", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
    @(negedge clk);
    total++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h12345678}) begin
      bad++; $display("FAIL rd_hold v=%b rdata=%h want 1 12345678", rsp_valid, rsp_rdata); end
    rsp_ready = 1;
    @(negedge clk); rsp_ready = 0;
    total++; if ({psel, rsp_valid, paddr} !== {3'b000, 1'b0, 16'h0020}) begin
      bad++; $display("FAIL rd_idle psel=%b v=%b paddr=%h want 000 0 0020", psel, rsp_valid, paddr); end
  endtask

  task automatic test_fifo_full;
    logic [15:0] seen [8];
    int got;
    pready = 1; rsp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      drive_cmd(1'b1, 2'd1, 16'h0100 + 16'(i), 32'(i));
      @(negedge clk);
    end
    total++; if ({cmd_ready, rsp_valid, psel} !== 5'b01000) begin
      bad++; $display("FAIL full_ready got=%b want=01000", {cmd_ready, rsp_valid, psel}); end
    drive_cmd(1'b1, 2'd1, 16'h01FF, 32'hFF);
    @(negedge clk); cmd_valid = 0;
    total++; if (cmd_ready !== 1'b0) begin
      bad++; $display("FAIL full_hold cmd_ready=%b want=0", cmd_ready); end
    rsp_ready = 1;
    @(negedge clk);
    total++; if ({cmd_ready, psel, paddr} !== {1'b1, 3'b010, 16'h0101}) begin
      bad++; $display("FAIL full_pop ready=%b psel=%b paddr=%h want 1 010 0101", cmd_ready, psel, paddr); end
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (psel != 0 && !penable && got < 8) begin seen[got] = paddr; got++; end
      @(negedge clk);
    end
    rsp_ready = 0;
    total++; if (got !== 4) begin
      bad++; $display("FAIL full_count got=%0d want=4", got); end
    for (int i = 0; i < 4 && i < got; i++) begin
      total++; if (seen[i] !== 16'h0101 + 16'(i)) begin
        bad++; $display("FAIL full_order%0d got=%h want=%h", i, seen[i], 16'h0101 + 16'(i)); end
    end
    total++; if (busy !== 1'b0) begin
      bad++; $display("FAIL full_drain busy=%b want=0", busy); end
  endtask

  task automatic test_decode_err;
    rsp_ready = 0;
    drive_cmd(1'b0, 2'd3, 16'h0999, 32'h0);
    @(negedge clk); cmd_valid = 0;
    total++; if ({rsp_valid, rsp_err, rsp_timeout, psel, penable, rsp_rdata} !== {3'b110, 3'b000, 1'b0, 32'h0}) begin
      bad++; $display("FAIL dec_resp v=%b err=%b to=%b psel=%b en=%b rdata=%h", rsp_valid, rsp_err, rsp_timeout, psel, penable, rsp_rdata); end
    total++; if (paddr !== 16'h0104) begin
      bad++; $display("FAIL dec_paddr got=%h want=0104", paddr); end
    rsp_ready = 1;
    @(negedge clk); rsp_ready = 0;
    total++; if ({busy, psel} !== 4'b0000) begin
      bad++; $display("FAIL dec_done got=%b want=0000", {busy, psel}); end
  endtask

  task automatic test_timeout;
    int n;
    pready = 0; prdata = 32'hFFFFFFFF;
    drive_cmd(1'b0, 2'd2, 16'h0030, 32'h0);
    @(negedge clk); cmd_valid = 0;
    total++; if ({psel, penable} !== 4'b1000) begin
      bad++; $display("FAIL to_setup got=%b want=1000", {psel, penable}); end
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (penable) n++;
    end
    total++; if ({rsp_valid, n} !== {1'b1, 32'd8}) begin
      bad++; $display("FAIL to_cycles valid=%b access=%0d want 1 8", rsp_valid, n); end
    total++; if ({rsp_err, rsp_timeout, rsp_rdata, psel, penable} !== {2'b11, 32'h0, 4'b0000}) begin
      bad++; $display("FAIL to_resp err=%b to=%b rdata=%h psel=%b", rsp_err, rsp_timeout, rsp_rdata, psel); end
    prdata = 0; rsp_ready = 1;
    @(negedge clk); rsp_ready = 0;
  endtask

  task automatic test_back_to_back;
    int stamp [4];
    int got;
    pready = 1; rsp_ready = 1; got = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 3) drive_cmd(1'b1, 2'd0, 16'h0200 + 16'(c), 32'(c));
      else cmd_valid = 0;
      @(negedge clk);
      if (psel != 0 && !penable && got < 4) begin
        stamp[got] = c + 1;
        total++; if (paddr !== 16'h0200 + 16'(got)) begin
          bad++; $display("FAIL b2b_addr%0d got=%h want=%h", got, paddr, 16'h0200 + 16'(got)); end
        got++;
      end
    end
    rsp_ready = 0;
    total++; if (got !== 3) begin
      bad++; $display("FAIL b2b_count got=%0d want=3", got); end
    for (int i = 0; i < 3 && i < got; i++) begin
      total++; if (stamp[i] !== 1 + 3 * i) begin
        bad++; $display("FAIL b2b_cycle%0d got=%0d want=%0d", i, stamp[i], 1 + 3 * i); end
    end
  endtask

  task automatic test_slverr_reset;
    pready = 1; pslverr = 1; rsp_ready = 0;
    drive_cmd(1'b1, 2'd0, 16'h0040, 32'h55);
    @(negedge clk); cmd_valid = 0;
    @(negedge clk);
    @(negedge clk);
    total++; if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b110, 32'h0}) begin
      bad++; $display("FAIL slverr v=%b err=%b to=%b rdata=%h want 1 1 0 0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
    rsp_ready = 1; pslverr = 0;
    @(negedge clk); rsp_ready = 0; pready = 0;
    drive_cmd(1'b1, 2'd1, 16'h0050, 32'h66);
    @(negedge clk);
    drive_cmd(1'b1, 2'd1, 16'h0060, 32'h77);
    @(negedge clk); cmd_valid = 0;
    total++; if ({psel, penable, busy} !== 5'b01011) begin
      bad++; $display("FAIL rst_pre got=%b want=01011", {psel, penable, busy}); end
    #2 rst_n = 0;
    #1;
    total++; if ({psel, penable, busy, rsp_valid, cmd_ready} !== 7'b0000001) begin
      bad++; $display("FAIL rst_async got=%b want=0000001", {psel, penable, busy, rsp_valid, cmd_ready}); end
    @(negedge clk); rst_n = 1;
    repeat (4) @(negedge clk);
    total++; if ({psel, busy, rsp_valid} !== 5'b00000) begin
      bad++; $display("FAIL rst_flush got=%b want=00000", {psel, busy, rsp_valid}); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read_wait;
    test_fifo_full;
    test_decode_err;
    test_timeout;
    test_back_to_back;
    test_slverr_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
